// File: rtl/ap_hs_txn_recorder.sv
// ap_hs_txn_recorder
//   Watches one ap_ctrl_hs handshake (ap_start/ap_ready/ap_done/ap_continue),
//   timestamps each transaction and queues one record per transaction in a
//   show-ahead FIFO that drains over rec_valid/rec_ready to the status dumper.
//
// Ports
//   clock, reset (async, active low)
//   ap_start/ap_ready/ap_done/ap_continue : monitored handshake
//   finish        : end of run; flushes an open transaction, blocks new ones
//   rec_valid/rec_ready, rec_ts_start/rec_ts_ready/rec_ts_done/rec_complete
//                 : FIFO head record and its handshake
//   txn_busy      : transaction open
//   overflow, drop_cnt : sticky drop flag, saturating drop count
//   flush_done    : finish seen, nothing open, FIFO empty
//   rec_interval  : start-to-start interval (only with AP_HS_TXN_INTERVAL_EN)
//
// Optional feature macro: AP_HS_TXN_INTERVAL_EN
module ap_hs_txn_recorder #(
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_continue,
  input  logic              finish,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [CNT_W-1:0]  rec_ts_start,
  output logic [CNT_W-1:0]  rec_ts_ready,
  output logic [CNT_W-1:0]  rec_ts_done,
  output logic              rec_complete,
  output logic              txn_busy,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
`ifdef AP_HS_TXN_INTERVAL_EN
  output logic [CNT_W-1:0]  rec_interval,
`endif
  output logic              flush_done
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

  typedef struct packed {
    logic [CNT_W-1:0] ts_start;
    logic [CNT_W-1:0] ts_ready;
    logic [CNT_W-1:0] ts_done;
    logic             complete;
`ifdef AP_HS_TXN_INTERVAL_EN
    logic [CNT_W-1:0] interval;
`endif
  } rec_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0]  t_start_q, t_start_d, t_ready_q, t_ready_d, t_done_q, t_done_d;
  logic              rdy_seen_q, rdy_seen_d;
  logic              finish_seen_q, finish_seen_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              flush_done_q, flush_done_d;
  rec_t              mem_q [DEPTH];
  rec_t              push_rec, head;
  logic              push, pop, full, wr_en, fin_rise;
  logic [CNT_W-1:0]  rdy_ts;
`ifdef AP_HS_TXN_INTERVAL_EN
  logic [CNT_W-1:0]  prev_start_q, prev_start_d;
  logic              have_prev_q, have_prev_d;
`endif

  always_comb begin
    state_d       = state_q;
    ts_d          = ts_q + CNT_W'(1);
    t_start_d     = t_start_q;
    t_ready_d     = t_ready_q;
    t_done_d      = t_done_q;
    rdy_seen_d    = rdy_seen_q;
    fin_rise      = finish && !finish_seen_q;
    finish_seen_d = finish_seen_q || finish;
    push          = 1'b0;
    push_rec      = '0;
    // ready timestamp for a record closing this cycle: a done with no
    // earlier ready reports ready at the closing timestamp
    rdy_ts        = rdy_seen_q ? t_ready_q : ts_q;

    case (state_q)
      S_IDLE: begin
        // finish in the same cycle as a start also blocks it
        if (ap_start && !finish_seen_q && !finish) begin
          t_start_d  = ts_q;
          t_ready_d  = ts_q;
          rdy_seen_d = ap_ready;
          if (ap_done && ap_continue) begin
            push     = 1'b1;
            push_rec.ts_start = ts_q;
            push_rec.ts_ready = ts_q;
            push_rec.ts_done  = ts_q;
            push_rec.complete = 1'b1;
          end else if (ap_done) begin
            t_done_d   = ts_q;
            rdy_seen_d = 1'b1;
            state_d    = S_HOLD;
          end else begin
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (ap_ready && !rdy_seen_q) begin
          t_ready_d  = ts_q;
          rdy_seen_d = 1'b1;
        end
        // a done takes precedence over a flush in the same cycle
        if ((ap_done && ap_continue) || fin_rise) begin
          push     = 1'b1;
          push_rec.ts_start = t_start_q;
          push_rec.ts_ready = rdy_ts;
          push_rec.ts_done  = ts_q;
          push_rec.complete = ap_done && ap_continue;
          state_d  = S_IDLE;
        end else if (ap_done) begin
          t_done_d   = ts_q;
          t_ready_d  = rdy_ts;
          rdy_seen_d = 1'b1;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ap_continue || fin_rise) begin
          push     = 1'b1;
          push_rec.ts_start = t_start_q;
          push_rec.ts_ready = t_ready_q;
          push_rec.ts_done  = ap_continue ? t_done_q : ts_q;
          push_rec.complete = ap_continue;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef AP_HS_TXN_INTERVAL_EN
    prev_start_d = prev_start_q;
    have_prev_d  = have_prev_q;
    // dropped records also advance the previous-start reference
    if (push) begin
      push_rec.interval = have_prev_q ? (push_rec.ts_start - prev_start_q) : '0;
      prev_start_d      = push_rec.ts_start;
      have_prev_d       = 1'b1;
    end
`endif

    // FIFO bookkeeping; a full FIFO still accepts a push when it pops too
    pop        = (cnt_q != '0) && rec_ready;
    full       = (cnt_q == (AW+1)'(DEPTH));
    wr_en      = push && (!full || pop);
    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d      = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (push && !wr_en) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end

    flush_done_d = finish_seen_d && (state_d == S_IDLE) && (cnt_d == '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ts_q          <= '0;
      t_start_q     <= '0;
      t_ready_q     <= '0;
      t_done_q      <= '0;
      rdy_seen_q    <= 1'b0;
      finish_seen_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      overflow_q    <= 1'b0;
      drop_cnt_q    <= '0;
      flush_done_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef AP_HS_TXN_INTERVAL_EN
      prev_start_q  <= '0;
      have_prev_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ts_q          <= ts_d;
      t_start_q     <= t_start_d;
      t_ready_q     <= t_ready_d;
      t_done_q      <= t_done_d;
      rdy_seen_q    <= rdy_seen_d;
      finish_seen_q <= finish_seen_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      overflow_q    <= overflow_d;
      drop_cnt_q    <= drop_cnt_d;
      flush_done_q  <= flush_done_d;
      if (wr_en) mem_q[wr_ptr_q] <= push_rec;
`ifdef AP_HS_TXN_INTERVAL_EN
      prev_start_q  <= prev_start_d;
      have_prev_q   <= have_prev_d;
`endif
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign rec_valid    = (cnt_q != '0);
  assign rec_ts_start = head.ts_start;
  assign rec_ts_ready = head.ts_ready;
  assign rec_ts_done  = head.ts_done;
  assign rec_complete = head.complete;
`ifdef AP_HS_TXN_INTERVAL_EN
  assign rec_interval = head.interval;
`endif
  assign txn_busy     = (state_q != S_IDLE);
  assign overflow     = overflow_q;
  assign drop_cnt     = drop_cnt_q;
  assign flush_done   = flush_done_q;
endmodule

// File: doc/ap_hs_txn_recorder.md
Name: ap_hs_txn_recorder

Overview:
- Synthesizable per-instance transaction recorder for ap_ctrl_hs handshakes (ap_start/ap_ready/ap_done/ap_continue) on accelerate-level and sub-function instances.
- Timestamps each transaction and buffers one record per transaction in a show-ahead FIFO.
- Upstream feeder of the module-status dump path: records drain over valid/ready to the sampler/CSV dumper, so sampling no longer has to observe the handshake live.

Parameters:
- CNT_W, 32: width of the timestamp counter and of every timestamp field.
- DEPTH, 16: record FIFO depth; power of 2, minimum 2.
- DROP_W, 16: width of the dropped-record counter.

Ports:
- clock, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset; low clears all state.
- ap_start, in, 1: monitored module start.
- ap_ready, in, 1: monitored module ready.
- ap_done, in, 1: monitored module done.
- ap_continue, in, 1: monitored module continue; tie 1'b1 for non-dataflow modules.
- finish, in, 1: end of simulation/run.
- rec_valid, out, 1: FIFO head record valid.
- rec_ready, in, 1: consumer accepts head.
- rec_ts_start, out, CNT_W: timestamp of transaction start.
- rec_ts_ready, out, CNT_W: timestamp of first ap_ready in the transaction.
- rec_ts_done, out, CNT_W: timestamp of the completing ap_done.
- rec_complete, out, 1: 1 = closed by done; 0 = flushed open by finish.
- txn_busy, out, 1: transaction open (state RUN or HOLD).
- overflow, out, 1: sticky; set on any dropped record.
- drop_cnt, out, DROP_W: dropped-record count, saturating.
- flush_done, out, 1: finish seen, no open transaction, FIFO empty.

Behaviour:
- Reset (reset low, async): ts=0, state IDLE, FIFO empty, rec_valid=0, all rec_* fields=0, txn_busy=0, overflow=0, drop_cnt=0, flush_done=0, finish_seen=0.
- ts: free-running, +1 every cycle out of reset; wraps modulo 2^CNT_W. All captures use the current cycle's ts.
- FSM states: IDLE, RUN, HOLD.
  - IDLE + ap_start=1 + !finish_seen: capture ts_start, go to RUN.
  - IDLE, same cycle as start, ap_ready=1: also capture ts_ready.
  - IDLE, same cycle as start, ap_done && ap_continue: push record with all three timestamps equal; stay IDLE.
  - RUN, first ap_ready=1: capture ts_ready; later ap_ready pulses are ignored.
  - RUN, ap_done=1 && ap_continue=1: push record (complete=1) and go to IDLE.
  - RUN, ap_done=1 && ap_continue=0: capture ts_done and go to HOLD.
  - HOLD, ap_continue=1: push record; ts_done is the first-done timestamp. Go to IDLE.
  - Done with no prior ap_ready: ts_ready = ts_done.
  - A start in the cycle after return to IDLE opens a new transaction (zero-gap back-to-back).
- finish: rising sample sets sticky finish_seen.
  - If RUN/HOLD: push an open record in the same cycle (complete=0, ts_done=current ts; ts_ready=ts if never seen) and go to IDLE.
  - Once finish_seen, no new transactions open.
  - flush_done = finish_seen && IDLE && FIFO empty; registered.
- FIFO:
  - rec_* outputs show the head, registered; rec_valid = !empty.
  - Pop occurs when rec_valid && rec_ready.
  - Push into full FIFO with no pop in the same cycle: record dropped, overflow<=1, drop_cnt+1 (saturates at all-ones).
  - Push and pop in the same cycle when full: both succeed, count unchanged.
  - Push into empty FIFO: rec_valid rises the next cycle (1-cycle latency).
  - Pointers wrap modulo DEPTH.
- Reset asserted mid-transaction: open transaction is discarded and no record is emitted.

Optional Feature:
- Macro: AP_HS_TXN_INTERVAL_EN.
- Defined: adds output rec_interval [CNT_W] = ts_start − previous transaction's ts_start (modulo 2^CNT_W), stored per record. The first record after reset has interval 0. Dropped records still update the previous-start register.
- Undefined: no port, no extra storage.

Test Plan:
- Single txn: reset release at cycle 0, ap_start at ts=5, ap_ready at 7, ap_done at 12, ap_continue=1 -> one record (5,7,12,complete=1); rec_valid at ts=13.
- Back-to-back: done at ts=12 with ap_start held, next done at 20 -> records (5,7,12) and (13,x,20); second ts_start=13.
- HOLD: ap_done at 10 with ap_continue=0, continue at 14 -> record ts_done=10, pushed at 14, txn_busy low from ts=15.
- Overflow: DEPTH=4, rec_ready=0, 6 transactions -> 4 records kept (oldest first), overflow=1, drop_cnt=2; full FIFO with push+pop same cycle -> drop_cnt unchanged.
- Finish mid-transaction: start at ts=3, finish at ts=9 -> record (3,9,9,complete=0); later ap_start ignored; flush_done=1 after drain.
- Async reset in RUN: reset low at ts=6 -> outputs zero immediately with no clock edge; no record after release.
